// File: rtl/nibble_serial_mag_cmp.sv
// Purpose : four_bit_gt is a 4-bit unsigned greater-than cell; nibble_serial_mag_cmp
//           compares two 4*NIBBLES-bit unsigned operands one nibble per clock, MSB first.
// Latency : cell is combinational; the comparator's done follows the accept edge by k cycles
//           (k = first differing nibble from MSB, 1-based, or NIBBLES when equal).
// Backpr. : none; start is only honoured in IDLE, a start seen in RUN or DONE is dropped.
//
// four_bit_gt ports:
//   a, b  : 4-bit unsigned nibbles
//   gt    : a > b
//
// nibble_serial_mag_cmp ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : request, accepted only in IDLE
//   a, b              : operands, captured on the accept edge
//   busy              : high while nibbles are being compared
//   done              : one-cycle pulse, flags valid from this cycle on
//   agtb, aeqb, altb  : one-hot result, held until the next accept or reset

module four_bit_gt (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt
);

  // Ripple from the MSB: a wins at bit i if all higher bits are equal
  // and a[i]=1, b[i]=0.
  logic [3:0] eq_bit;
  logic [3:0] win_bit;

  assign eq_bit  = ~(a ^ b);
  assign win_bit = a & ~b;

  assign gt = win_bit[3]
            | (eq_bit[3] & win_bit[2])
            | (eq_bit[3] & eq_bit[2] & win_bit[1])
            | (eq_bit[3] & eq_bit[2] & eq_bit[1] & win_bit[0]);

endmodule

module nibble_serial_mag_cmp #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 agtb,
  output logic                 aeqb,
  output logic                 altb
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IDXW-1:0] idx;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic            gt;
  logic            lt;

  // Nibble select as an explicit mux over legal positions, so idx widths
  // wider than needed (non power-of-two NIBBLES) never address past W.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // Same cell twice with swapped operands: neither set means nibbles equal.
  four_bit_gt u_a_gt_b (
    .a  (a_nib),
    .b  (b_nib),
    .gt (gt)
  );

  four_bit_gt u_b_gt_a (
    .a  (b_nib),
    .b  (a_nib),
    .gt (lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      agtb  <= 1'b0;
      aeqb  <= 1'b0;
      altb  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDXW'(NIBBLES - 1);
            agtb  <= 1'b0;
            aeqb  <= 1'b0;
            altb  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (gt) begin
            agtb  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (lt) begin
            altb  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (idx == '0) begin
            // Last nibble matched: operands equal. idx never wraps.
            aeqb  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - IDXW'(1);
          end
        end

        DONE: begin
          // start is ignored here; the next accept is in IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_mag_cmp.sv
module tb_nibble_serial_mag_cmp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // NIBBLES=4 instance
  logic        start4 = 1'b0;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic        busy4, done4, agtb4, aeqb4, altb4;

  // NIBBLES=1 instance
  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1, done1, agtb1, aeqb1, altb1;

  int n_tests = 0;
  int n_fail  = 0;

  // Which instance the shared run task observes.
  int cur_nib = 4;

  logic       obs_busy, obs_done;
  logic [2:0] obs_flags;

  always #5 clk = ~clk;

  nibble_serial_mag_cmp #(.NIBBLES(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .agtb  (agtb4),
    .aeqb  (aeqb4),
    .altb  (altb4)
  );

  nibble_serial_mag_cmp #(.NIBBLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .agtb  (agtb1),
    .aeqb  (aeqb1),
    .altb  (altb1)
  );

  assign obs_busy  = (cur_nib == 1) ? busy1 : busy4;
  assign obs_done  = (cur_nib == 1) ? done1 : done4;
  assign obs_flags = (cur_nib == 1) ? {agtb1, aeqb1, altb1} : {agtb4, aeqb4, altb4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expected flags {gt,eq,lt} from plain integer comparison.
  function automatic logic [2:0] ref_flags(input logic [63:0] av, input logic [63:0] bv);
    return {av > bv, av == bv, av < bv};
  endfunction

  // Reference: cycles from accept edge to done = position (from MSB, 1-based)
  // of the first nibble where the operand prefixes differ; n if equal.
  function automatic int ref_lat(input logic [63:0] av, input logic [63:0] bv, input int n);
    for (int k = 1; k <= n; k++) begin
      if ((av >> (4 * (n - k))) != (bv >> (4 * (n - k)))) return k;
    end
    return n;
  endfunction

  // Runs one comparison. Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_cmp(input logic [63:0] av, input logic [63:0] bv, input bit scramble);
    int         k;
    int         cnt;
    int         busy_cnt;
    bit         seen;
    logic [2:0] exp;
    logic [63:0] mask;
    mask = (cur_nib == 1) ? 64'hF : 64'hFFFF;
    av  &= mask;
    bv  &= mask;
    k   = ref_lat(av, bv, cur_nib);
    exp = ref_flags(av, bv);
    if (cur_nib == 1) begin a1 = av[3:0]; b1 = bv[3:0]; start1 = 1'b1; end
    else              begin a4 = av[15:0]; b4 = bv[15:0]; start4 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
    check("busy_after_accept", 32'(obs_busy), 32'd1);
    check("flags_cleared_on_accept", 32'(obs_flags), 32'd0);
    cnt = 0; busy_cnt = 0; seen = 0;
    while (!seen && cnt < 40) begin
      if (obs_busy) busy_cnt++;
      if (scramble) begin
        a4 = 16'($urandom); b4 = 16'($urandom);
        a1 = 4'($urandom);  b1 = 4'($urandom);
      end
      @(posedge clk); #1;
      cnt++;
      if (obs_done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 32'(cnt), 32'(k));
      return;
    end
    check("latency", 32'(cnt), 32'(k));
    check("busy_cycles", 32'(busy_cnt), 32'(k));
    check("busy_low_at_done", 32'(obs_busy), 32'd0);
    check("flags", 32'(obs_flags), 32'(exp));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(obs_done), 32'd0);
    check("flags_held", 32'(obs_flags), 32'(exp));
  endtask

  initial begin
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [2:0]  last_exp;
    logic [63:0] ra, rb;
    int          edges, exp_edge, pi, extra_done;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_flags4", 32'({agtb4, aeqb4, altb4}), 32'd0);
    check("rst_flags1", 32'({agtb1, aeqb1, altb1}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed NIBBLES=4 cases
    cur_nib = 4;
    run_cmp(64'h8000, 64'h7FFF, 0);
    run_cmp(64'h1234, 64'h1235, 0);
    run_cmp(64'hABCD, 64'hABCD, 0);
    run_cmp(64'h12F0, 64'h1200, 1);
    run_cmp(64'h0000, 64'hFFFF, 1);

    // Reset in RUN discards the comparison; flags held from before also clear.
    a4 = 16'h1234; b4 = 16'h1235; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_busy", 32'(busy4), 32'd0);
    check("midrun_rst_done", 32'(done4), 32'd0);
    check("midrun_rst_flags", 32'({agtb4, aeqb4, altb4}), 32'd0);
    reset = 1'b0;
    extra_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4 || busy4) extra_done++;
    end
    check("midrun_rst_no_done", 32'(extra_done), 32'd0);

    // Start pulse during DONE is dropped.
    a4 = 16'h9000; b4 = 16'h1000; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    check("pre_drop_done", 32'(done4), 32'd1);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    extra_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4 || busy4) extra_done++;
    end
    check("start_in_done_dropped", 32'(extra_done), 32'd0);
    check("flags_after_drop", 32'({agtb4, aeqb4, altb4}), 32'b100);

    // start held high: accepts only from IDLE, period k+2.
    pa[0] = 16'h8000; pb[0] = 16'h7FFF;
    pa[1] = 16'h1234; pb[1] = 16'h1235;
    pa[2] = 16'hABCD; pb[2] = 16'hABCD;
    pa[3] = 16'h12F0; pb[3] = 16'h1200;
    pi = 0; edges = 0;
    last_exp = ref_flags(64'(pa[0]), 64'(pb[0]));
    a4 = pa[0]; b4 = pb[0]; start4 = 1'b1;
    exp_edge = 1 + ref_lat(64'(pa[0]), 64'(pb[0]), 4);
    while (pi < 4 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (done4) begin
        check("hold_done_edge", 32'(edges), 32'(exp_edge));
        check("hold_flags", 32'({agtb4, aeqb4, altb4}), 32'(ref_flags(64'(pa[pi]), 64'(pb[pi]))));
        last_exp = ref_flags(64'(pa[pi]), 64'(pb[pi]));
        pi++;
        if (pi < 4) begin
          a4 = pa[pi]; b4 = pb[pi];
          exp_edge = edges + 2 + ref_lat(64'(pa[pi]), 64'(pb[pi]), 4);
        end
      end else if (!busy4 && pi > 0) begin
        check("hold_flags_held", 32'({agtb4, aeqb4, altb4}), 32'(last_exp));
      end
    end
    start4 = 1'b0;
    if (pi < 4) check("hold_timeout", 32'(pi), 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // NIBBLES=1 instance
    cur_nib = 1;
    run_cmp(64'hF, 64'hE, 0);
    run_cmp(64'h3, 64'h9, 0);
    run_cmp(64'h7, 64'h7, 1);
    for (int i = 0; i < 20; i++) run_cmp(64'($urandom), 64'($urandom), 0);

    // Random regression at NIBBLES=4, biased toward shared prefixes so all
    // latencies occur.
    cur_nib = 4;
    for (int i = 0; i < 1000; i++) begin
      int pos;
      ra = 64'($urandom_range(0, 16'hFFFF));
      rb = ra;
      case ($urandom_range(0, 3))
        0: rb = 64'($urandom_range(0, 16'hFFFF));
        1: ;
        default: begin
          pos = $urandom_range(0, 3);
          rb[4*pos +: 4] = 4'($urandom);
          for (int j = 0; j < pos; j++) rb[4*j +: 4] = 4'($urandom);
        end
      endcase
      run_cmp(ra, rb, i[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
